// File: rtl/conv3_pkg.sv
// Shared definitions for the 3x3 convolution stream sequencer: FSM states,
// window geometry and the flattening rule used for kernel and window buses.
package conv3_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int KSIZE          = 3;
  localparam int DATA_WIDTH_DEF = 5;

  // Datapath result width: nine full-width products plus growth headroom.
  function automatic int res_width(input int dw);
    return 2 * dw + 4;
  endfunction

  localparam int RES_W = res_width(DATA_WIDTH_DEF);

  // Element [r][c] of a 3x3 bus lives at slot r*3+c (slot 0 = oldest row/col).
  function automatic int kidx(input int r, input int c);
    return r * KSIZE + c;
  endfunction

endpackage

// File: rtl/conv3_res_fifo.sv
// Small synchronous FIFO holding datapath results until the consumer takes
// them. Pushes while full and pops while empty are dropped.
module conv3_res_fifo
  import conv3_pkg::*;
#(
  parameter int WIDTH = RES_W,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/conv3_stream_ctrl.sv
// Raster-stream to 3x3 window sequencer for a fixed-latency convolution
// datapath. Buffers two image lines, issues one window per accepted pixel
// once a full window exists, and collects the results in a FIFO. Because the
// datapath cannot stall, pixels are only accepted while every result that
// could still arrive is guaranteed a FIFO slot.
module conv3_stream_ctrl
  import conv3_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int DP_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_kernel_valid,
  input  logic [9*DATA_WIDTH-1:0]     i_kernel,
  input  logic                        i_pix_valid,
  input  logic [DATA_WIDTH-1:0]       i_pix,
  output logic                        o_pix_ready,
  output logic [9*DATA_WIDTH-1:0]     o_win,
  output logic [9*DATA_WIDTH-1:0]     o_kernel,
  input  logic [2*DATA_WIDTH+3:0]     i_conv_result,
  output logic                        o_res_valid,
  output logic [2*DATA_WIDTH+3:0]     o_res,
  input  logic                        i_res_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int RW   = res_width(DATA_WIDTH);
  localparam int KW   = KSIZE * KSIZE * DATA_WIDTH;
  localparam int CW   = $clog2(IMG_W);
  localparam int ROWW = $clog2(IMG_H);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_H - 1);
  localparam logic [CW-1:0]   COL_TWO  = CW'(2);
  localparam logic [ROWW-1:0] ROW_TWO  = ROWW'(2);

  state_t state_r;
  state_t next_s;

  logic [CW-1:0]   col_r;
  logic [ROWW-1:0] row_r;
  logic [KW-1:0]   kernel_r;
  logic [KW-1:0]   win_r;
  logic            busy_r;
  logic            done_r;

  // Line buffers: lb1 holds the previous row, lb2 the row before that.
  logic [DATA_WIDTH-1:0] lb1_r  [IMG_W];
  logic [DATA_WIDTH-1:0] lb2_r  [IMG_W];
  // Two most recent window columns, oldest at index 0.
  logic [DATA_WIDTH-1:0] hist_r [KSIZE][KSIZE-1];
  // Incoming column {row-2, row-1, current}.
  logic [DATA_WIDTH-1:0] col_s  [KSIZE];

  logic              issue_r;
  logic [DP_LAT-1:0] pipe_r;
  logic [7:0]        inflight_s;
  logic [7:0]        occ_s;

  logic [FCW-1:0]    fifo_count_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;

  logic              pix_ready_s;
  logic              accept_s;
  logic              issue_s;
  logic              last_s;
  logic              kload_s;

  assign kload_s     = (state_r == LOAD_K) && i_kernel_valid;
  assign occ_s       = 8'(fifo_count_s) + inflight_s;
  assign pix_ready_s = (state_r == STREAM) && (occ_s < 8'(FIFO_DEPTH)) && !fifo_full_s;
  assign accept_s    = i_pix_valid && pix_ready_s;
  assign issue_s     = accept_s && (row_r >= ROW_TWO) && (col_r >= COL_TWO);
  assign last_s      = accept_s && (row_r == ROW_LAST) && (col_r == COL_LAST);

  assign col_s[0] = lb2_r[IMG_W-1];
  assign col_s[1] = lb1_r[IMG_W-1];
  assign col_s[2] = i_pix;

  assign fifo_push_s = pipe_r[DP_LAT-1];
  assign fifo_pop_s  = !fifo_empty_s && i_res_ready;

  assign o_pix_ready = pix_ready_s;
  assign o_win       = win_r;
  assign o_kernel    = kernel_r;
  assign o_res_valid = !fifo_empty_s;
  assign o_busy      = busy_r;
  assign o_done      = done_r;

  // Results issued but not yet in the FIFO: issue flag plus the delay pipe.
  always_comb begin
    inflight_s = {7'd0, issue_r};
    for (int i = 0; i < DP_LAT; i++) begin
      inflight_s = inflight_s + {7'd0, pipe_r[i]};
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          next_s = LOAD_K;
        end else begin
          next_s = IDLE;
        end
      end
      LOAD_K: begin
        if (i_kernel_valid) begin
          next_s = STREAM;
        end else begin
          next_s = LOAD_K;
        end
      end
      STREAM: begin
        if (last_s) begin
          next_s = DRAIN;
        end else begin
          next_s = STREAM;
        end
      end
      DRAIN: begin
        if ((inflight_s == 8'd0) && fifo_empty_s) begin
          next_s = DONE;
        end else begin
          next_s = DRAIN;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != IDLE);
      done_r  <= (next_s == DONE);
    end
  end

  // Kernel latch: captured once per frame in LOAD_K.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      kernel_r <= {KW{1'b0}};
    end else if (kload_s) begin
      kernel_r <= i_kernel;
    end
  end

  // Raster position of the next pixel; restarts whenever a frame begins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {ROWW{1'b0}};
    end else if (kload_s) begin
      col_r <= {CW{1'b0}};
      row_r <= {ROWW{1'b0}};
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= {CW{1'b0}};
        row_r <= (row_r == ROW_LAST) ? {ROWW{1'b0}} : row_r + ROWW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Line buffers and column history shift only on an accepted pixel.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      lb1_r[0] <= i_pix;
      lb2_r[0] <= lb1_r[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb1_r[i] <= lb1_r[i-1];
        lb2_r[i] <= lb2_r[i-1];
      end
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 2; c++) begin
          hist_r[r][c] <= hist_r[r][c+1];
        end
        hist_r[r][KSIZE-2] <= col_s[r];
      end
    end
  end

  // Window issue: register the full 3x3 window and track it down the
  // datapath latency so the matching result is captured on arrival.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      win_r   <= {KW{1'b0}};
      issue_r <= 1'b0;
      pipe_r  <= {DP_LAT{1'b0}};
    end else begin
      issue_r   <= issue_s;
      pipe_r[0] <= issue_r;
      for (int i = 1; i < DP_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      if (issue_s) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) begin
            win_r[kidx(r, c)*DATA_WIDTH +: DATA_WIDTH] <= hist_r[r][c];
          end
          win_r[kidx(r, KSIZE-1)*DATA_WIDTH +: DATA_WIDTH] <= col_s[r];
        end
      end
    end
  end

  conv3_res_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (fifo_push_s),
    .wdata (i_conv_result),
    .pop   (fifo_pop_s),
    .rdata (o_res),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

endmodule

// File: doc/conv3_stream_ctrl.md
Name: conv3_stream_ctrl

Overview:
Sequencer that turns a raster-order pixel stream into 3x3 windows for the pipelined 3x3 convolution datapath. It holds the kernel, buffers two image lines, and issues one window per accepted pixel once a full window exists. It tracks the datapath's fixed 2-cycle latency and stores results in a small output FIFO. The datapath has no stall input, so a credit scheme provides backpressure.

Parameters:
DATA_WIDTH, 5, signed pixel/kernel element width (2's complement)
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
DP_LAT, 2, datapath latency: window driven in cycle c -> result on i_conv_result in cycle c+DP_LAT
FIFO_DEPTH, 4, result FIFO entries (>= DP_LAT+2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_start  in  1  start pulse; accepted only in IDLE
i_kernel_valid  in  1  kernel word valid; accepted only in LOAD_K
i_kernel  in  9*DATA_WIDTH  kernel, element [r][c] at bits (r*3+c)*DATA_WIDTH +: DATA_WIDTH
i_pix_valid  in  1  pixel valid
i_pix  in  DATA_WIDTH  signed pixel, raster order
o_pix_ready  out  1  pixel accepted when i_pix_valid && o_pix_ready
o_win  out  9*DATA_WIDTH  window to datapath, same packing as i_kernel; [0][0] = oldest row/col
o_kernel  out  9*DATA_WIDTH  latched kernel to datapath
i_conv_result  in  2*DATA_WIDTH+4  datapath result
o_res_valid  out  1  result valid (FIFO non-empty)
o_res  out  2*DATA_WIDTH+4  FIFO head
i_res_ready  in  1  result consumer ready
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset: state IDLE, counters 0, FIFO empty, in-flight pipe cleared. o_pix_ready=0, o_res_valid=0, o_busy=0, o_done=0, o_win=0, o_kernel=0. Line buffer contents are don't-care. Reset mid-frame aborts the frame; no partial results survive.
- FSM: IDLE -(i_start)-> LOAD_K -(i_kernel_valid, kernel latched)-> STREAM -(last pixel accepted)-> DRAIN -(inflight==0 && FIFO empty)-> DONE -> IDLE.
  - DONE lasts 1 cycle; o_done=1 only in DONE.
  - i_kernel_valid outside LOAD_K is ignored; i_start outside IDLE is ignored.
- Pixel acceptance: o_pix_ready = (state==STREAM) && (fifo_count + inflight < FIFO_DEPTH). This applies to every pixel, including those that produce no window. It guarantees every issued result has a FIFO slot.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on accept. col wraps to 0 and row increments. Accepting (row=IMG_H-1, col=IMG_W-1) moves to DRAIN.
- Line buffers: two IMG_W-deep shift buffers holding rows r-1 and r-2. A 3x3 shift window is built from the {row-2, row-1, current} column. Both update on accept only.
- Issue: an accept with row>=2 && col>=2 registers o_win and sets issue flag at the clock edge. o_win is therefore valid in the cycle after the accept.
  - The issue flag shifts through a DP_LAT-deep valid pipe. When the pipe's tail is set, i_conv_result is pushed into the FIFO that cycle.
  - Accept to o_res_valid is 4 cycles with an empty FIFO and DP_LAT=2.
- inflight = popcount(issue flag + valid pipe), range 0..DP_LAT+1.
- FIFO: push from the pipe, pop on o_res_valid && i_res_ready. A simultaneous push and pop leaves the count unchanged. Overflow is unreachable by construction; the bench asserts it never occurs.
- Results per frame: (IMG_W-2)*(IMG_H-2), in raster order of window centres. Values are passed through unmodified (no saturation); datapath width 2*DATA_WIDTH+4 cannot overflow.
- The pixel stream restarts clean each frame: counters reset on entering STREAM, and no cross-frame window is emitted.

Decomposition:
- Shared package conv3_pkg holds:
  - state enum (IDLE, LOAD_K, STREAM, DRAIN, DONE)
  - localparams KSIZE=3 and RES_W=2*DATA_WIDTH+4
  - pack/unpack index function for the 3x3 flattening
- One sub-module: conv3_res_fifo, a synchronous FIFO with parameters width/depth and outputs count, empty, full.
- Line buffers and window stay inline.

Test Plan:
- Kernel all +1, 8x8 frame of pixel=+1, i_res_ready=1 -> exactly 36 results, all 9; o_done pulses once; first o_res_valid 4 cycles after accepting pixel (2,2).
- Kernel centre=+1 else 0, pixel=(r*8+c)%16-8 -> results equal the centre pixel in raster order (first = pixel(1,1) = 1, then 2, 3, ...).
- Extremes: kernel all -16, pixels all -16 -> each result 2304; kernel all +15, pixels all -16 -> -2160.
- i_res_ready=0 for 20 cycles mid-frame -> o_pix_ready drops when fifo_count+inflight reaches 4; no result lost or duplicated; resumes on ready.
- Assert i_rst_n=0 at pixel 30 then restart -> outputs at reset values next cycle; the new frame yields exactly 36 correct results.
- i_kernel_valid in IDLE and i_start in STREAM -> both ignored; the kernel used is the one latched in LOAD_K.
